sweep_response_meter: RTL
=========================

SWEEP_RESPONSE_METER -- requirements
Module: sweep_response_meter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the signed filter-output samples being measured.
REQ-002 SHALL have parameter SETTLE_SAMPLES, default 48, the number of valid samples discarded after each frequency step.
REQ-003 SHALL have parameter WINDOW_SAMPLES, default 960, the number of valid samples measured per step.
REQ-004 SHALL have parameter SWEEP_STEPS, default 10, the number of frequency steps per sweep.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin a sweep.
REQ-008 SHALL have port sample_valid, input, 1 bit: sample_in is valid this cycle.
REQ-009 SHALL have port sample_in, input, DATA_WIDTH bits: signed IIR filter output sample.
REQ-010 SHALL have port result_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port step_advance, output, 1 bit: one-cycle pulse telling the stimulus source to move to the next frequency.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port result_valid, output, 1 bit: a result is presented.
REQ-014 SHALL have port result_step, output, clog2(SWEEP_STEPS) bits: step index of the result.
REQ-015 SHALL have port result_max, output, DATA_WIDTH bits: signed maximum in the window.
REQ-016 SHALL have port result_min, output, DATA_WIDTH bits: signed minimum in the window.
REQ-017 SHALL have port result_p2p, output, DATA_WIDTH+1 bits: unsigned max minus min.
REQ-018 SHALL have port done, output, 1 bit: one-cycle pulse when the final result is accepted.

Function
REQ-019 SHALL implement the states IDLE, SETTLE, MEASURE and REPORT.
REQ-020 IDLE: start moves to SETTLE with the step counter at 0; start received in any other state SHALL be ignored.
REQ-021 SETTLE: only cycles with sample_valid=1 SHALL count; after SETTLE_SAMPLES valid samples the block SHALL enter MEASURE. Those samples are not tracked.
REQ-022 MEASURE: the first valid sample SHALL load both max and min; each later valid sample SHALL update max and min by signed compare.
REQ-023 MEASURE: after the WINDOW_SAMPLES-th valid sample, that sample included, the block SHALL enter REPORT on the next cycle.
REQ-024 Invalid cycles SHALL neither count nor update the tracker in any state.
REQ-025 REPORT: result_valid=1 and all result fields SHALL stay stable until result_valid and result_ready are both high; samples arriving during REPORT SHALL be ignored.
REQ-026 result_p2p SHALL equal max minus min, computed at DATA_WIDTH+1 bits with no overflow.
REQ-027 On acceptance, if step is below SWEEP_STEPS-1: step_advance SHALL pulse for 1 cycle, step SHALL increment, and the block SHALL return to SETTLE.
REQ-028 On acceptance, if step equals SWEEP_STEPS-1: done SHALL pulse for 1 cycle and the block SHALL return to IDLE.
REQ-029 Latency from the last window sample to result_valid SHALL be 1 cycle; result_valid SHALL drop the cycle after acceptance.

Reset
REQ-030 rst=1 in any state, including mid-MEASURE or mid-REPORT, SHALL force IDLE on the next edge.
REQ-031 Under reset: step, sample counter, max and min SHALL clear to 0; all outputs SHALL be 0 (busy, result_valid, step_advance, done, result_step, result_max, result_min, result_p2p).
REQ-032 A start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-033 Package iir_sweep_pkg SHALL hold the state enum, DATA_WIDTH default and the width constants for step and count.
REQ-034 Sub-module minmax_tracker (clear, load-first, update, signed max/min outputs) SHALL be instantiated once.

Verification (bench parameters: SETTLE=4, WINDOW=8, STEPS=3, DATA_WIDTH=32)
REQ-035 Constant sample 100 on every cycle -> result_max=100, result_min=100, result_p2p=0, result_step=0.
REQ-036 Alternating +1000/-1000 samples -> result_max=1000, result_min=-1000, result_p2p=2000.
REQ-037 Window contains 0x7FFFFFFF and 0x80000000 -> result_p2p=0x0FFFFFFFF (33 bits), with no wrap.
REQ-038 sample_valid toggling every other cycle and result_ready low for 5 cycles -> result_valid held with stable fields; only valid samples counted (30 cycles per window).
REQ-039 Full sweep with 3 steps -> results at steps 0, 1, 2; exactly 2 step_advance pulses; 1 done pulse; then busy=0.
REQ-040 rst at the 3rd sample of MEASURE -> all outputs 0 on the next cycle; a following start -> result_step=0 with a fresh window.

Source files
------------

// File: rtl/sweep_response_meter_pkg.sv
// -----------------------------------------------------------------------------
// iir_sweep_pkg
// Purpose : shared types and constants for the sweep response meter.
//           Holds the measurement FSM state enum, the default sample width
//           and helpers that size the step and sample counters.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package iir_sweep_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int SETTLE_SAMPLES_DEFAULT = 48;
  localparam int WINDOW_SAMPLES_DEFAULT = 960;
  localparam int SWEEP_STEPS_DEFAULT    = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  // Bits needed to index 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int STEP_W_DEFAULT = width_of(SWEEP_STEPS_DEFAULT);
  localparam int CNT_W_DEFAULT  = width_of((SETTLE_SAMPLES_DEFAULT > WINDOW_SAMPLES_DEFAULT) ?
                                           SETTLE_SAMPLES_DEFAULT : WINDOW_SAMPLES_DEFAULT);

endpackage

// File: rtl/sweep_response_meter_if.sv
// -----------------------------------------------------------------------------
// sweep_response_meter_if
// Purpose : bundles the sample stream, the control strobes and the result
//           handshake of the sweep response meter.
// Signals : start, sample_valid, sample_in, result_ready  (stimulus side out)
//           step_advance, busy, result_valid, result_step,
//           result_max, result_min, result_p2p, done      (meter side out)
// Modports: master - stimulus/consumer side, slave - meter side.
// -----------------------------------------------------------------------------
interface sweep_response_meter_if
  import iir_sweep_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int STEP_W     = STEP_W_DEFAULT
);
  logic                  start;
  logic                  sample_valid;
  logic [DATA_WIDTH-1:0] sample_in;
  logic                  result_ready;
  logic                  step_advance;
  logic                  busy;
  logic                  result_valid;
  logic [STEP_W-1:0]     result_step;
  logic [DATA_WIDTH-1:0] result_max;
  logic [DATA_WIDTH-1:0] result_min;
  logic [DATA_WIDTH:0]   result_p2p;
  logic                  done;

  modport master (
    output start, sample_valid, sample_in, result_ready,
    input  step_advance, busy, result_valid, result_step,
           result_max, result_min, result_p2p, done
  );

  modport slave (
    input  start, sample_valid, sample_in, result_ready,
    output step_advance, busy, result_valid, result_step,
           result_max, result_min, result_p2p, done
  );
endinterface

// File: rtl/sweep_response_meter_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
// Purpose : running signed maximum / minimum of a sample stream.
// Ports   : clk, rst     - clock, synchronous active-high reset
//           i_clear      - zero both extremes
//           i_load       - first sample of a window: load max and min
//           i_update     - later sample: signed compare-and-replace
//           i_sample     - signed sample
//           o_max, o_min - current extremes
// -----------------------------------------------------------------------------
module minmax_tracker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_update,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [DATA_WIDTH-1:0] o_min
);

  logic signed [DATA_WIDTH-1:0] r_max;
  logic signed [DATA_WIDTH-1:0] r_min;
  logic signed [DATA_WIDTH-1:0] w_sample;

  assign w_sample = $signed(i_sample);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_max <= '0;
      r_min <= '0;
    end else if (i_load) begin
      r_max <= w_sample;
      r_min <= w_sample;
    end else if (i_update) begin
      if (w_sample > r_max) r_max <= w_sample;
      if (w_sample < r_min) r_min <= w_sample;
    end
  end

  assign o_max = r_max;
  assign o_min = r_min;

endmodule

// File: rtl/sweep_response_meter.sv
// -----------------------------------------------------------------------------
// sweep_response_meter
// Purpose : measures the response of a filter across a frequency sweep.
//           For each step it drops SETTLE_SAMPLES valid samples, tracks the
//           signed max/min over WINDOW_SAMPLES valid samples, then holds the
//           result until the consumer accepts it and requests the next step.
// Ports   : clk, rst                  - clock, synchronous active-high reset
//           start                     - begin a sweep (honoured in IDLE only)
//           sample_valid, sample_in   - signed sample stream
//           result_ready              - consumer accepts the result
//           step_advance              - pulse: move stimulus to next frequency
//           busy                      - not IDLE
//           result_valid/_step/_max/_min/_p2p - presented result
//           done                      - pulse: final result accepted
// -----------------------------------------------------------------------------
module sweep_response_meter
  import iir_sweep_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int SETTLE_SAMPLES = SETTLE_SAMPLES_DEFAULT,
  parameter int WINDOW_SAMPLES = WINDOW_SAMPLES_DEFAULT,
  parameter int SWEEP_STEPS    = SWEEP_STEPS_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              sample_valid,
  input  logic [DATA_WIDTH-1:0]             sample_in,
  input  logic                              result_ready,
  output logic                              step_advance,
  output logic                              busy,
  output logic                              result_valid,
  output logic [width_of(SWEEP_STEPS)-1:0]  result_step,
  output logic [DATA_WIDTH-1:0]             result_max,
  output logic [DATA_WIDTH-1:0]             result_min,
  output logic [DATA_WIDTH:0]               result_p2p,
  output logic                              done
);

  localparam int STEP_W = width_of(SWEEP_STEPS);
  localparam int CNT_W  = width_of((SETTLE_SAMPLES > WINDOW_SAMPLES) ?
                                   SETTLE_SAMPLES : WINDOW_SAMPLES);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  WINDOW_LAST = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(SWEEP_STEPS - 1);

  state_t              r_state;
  logic [STEP_W-1:0]   r_step;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_step_advance;
  logic                r_done;

  logic                w_measure_valid;
  logic                w_load;
  logic                w_update;
  logic                w_clear;
  logic [DATA_WIDTH-1:0] w_max;
  logic [DATA_WIDTH-1:0] w_min;
  logic [DATA_WIDTH:0]   w_p2p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_step         <= '0;
      r_cnt          <= '0;
      r_step_advance <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_step_advance <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SETTLE;
            r_step  <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SETTLE: begin
          if (sample_valid) begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_MEASURE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_MEASURE: begin
          if (sample_valid) begin
            if (r_cnt == WINDOW_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_REPORT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_REPORT: begin
          if (result_ready) begin
            r_cnt <= '0;
            if (r_step == STEP_LAST) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_step_advance <= 1'b1;
              r_step         <= r_step + 1'b1;
              r_state        <= ST_SETTLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The window's first valid sample seeds both extremes, so stale values from
  // an earlier step or an aborted window never leak into a result.
  assign w_measure_valid = (r_state == ST_MEASURE) && sample_valid;
  assign w_load          = w_measure_valid && (r_cnt == '0);
  assign w_update        = w_measure_valid && (r_cnt != '0);
  assign w_clear         = (r_state == ST_IDLE) && start;

  minmax_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_load   (w_load),
    .i_update (w_update),
    .i_sample (sample_in),
    .o_max    (w_max),
    .o_min    (w_min)
  );

  // Sign-extend both operands by one bit: the true difference of two signed
  // N-bit values always fits in N+1 unsigned bits.
  assign w_p2p = {w_max[DATA_WIDTH-1], w_max} - {w_min[DATA_WIDTH-1], w_min};

  // Result fields are only driven while a result is presented, so they read
  // zero in IDLE and across reset.
  assign busy         = (r_state != ST_IDLE);
  assign result_valid = (r_state == ST_REPORT);
  assign result_step  = result_valid ? r_step : '0;
  assign result_max   = result_valid ? w_max  : '0;
  assign result_min   = result_valid ? w_min  : '0;
  assign result_p2p   = result_valid ? w_p2p  : '0;
  assign step_advance = r_step_advance;
  assign done         = r_done;

endmodule
